// File: rtl/icache_bk_control.sv
// Direct-mapped I-cache controller: owns tags and valid bits, answers hits in the same cycle, and sequences line fills.
// Optional ICACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module icache_bk_control #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_address,
    input  logic               mem_read,
    output logic [31:0]        mem_rdata,
    output logic               mem_resp,
    output logic [31:0]        pmem_address,
    output logic               pmem_read,
    input  logic [255:0]       pmem_rdata,
    input  logic               pmem_resp,
    output logic               data_web,
    output logic [INDEX_W-1:0] data_index,
    output logic [255:0]       data_datain,
    input  logic [255:0]       data_dataout
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

    state_t             state;
    logic [TAG_W-1:0]   tags [SETS];
    logic [SETS-1:0]    valid;
    logic [31:2]        lat_addr;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] lat_idx;
    logic               hit;
    logic               idle_hit;
    logic               idle_miss;
    logic [2:0]         word_sel;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^mem_address[1:0];

    assign req_tag   = mem_address[31 -: TAG_W];
    assign req_idx   = mem_address[5 +: INDEX_W];
    assign lat_tag   = lat_addr[31 -: TAG_W];
    assign lat_idx   = lat_addr[5 +: INDEX_W];
    assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);
    assign idle_hit  = (state == IDLE) && mem_read && hit;
    assign idle_miss = (state == IDLE) && mem_read && !hit;

    // RESPOND serves the word of the latched address, not whatever the requester drives now
    assign word_sel = (state == RESPOND) ? lat_addr[4:2] : mem_address[4:2];

    always_comb begin
        mem_rdata   = '0;
        mem_resp    = 1'b0;
        data_index  = '0;
        data_web    = 1'b0;
        data_datain = pmem_rdata;
        if (!rst) begin
            mem_rdata  = data_dataout[{word_sel, 5'b0} +: 32];
            mem_resp   = idle_hit || ((state == RESPOND) && mem_read);
            data_index = (state == IDLE) ? req_idx : lat_idx;
            data_web   = (state == FILL) && pmem_resp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            lat_addr     <= '0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_miss) begin
                        lat_addr     <= mem_address[31:2];
                        pmem_read    <= 1'b1;
                        pmem_address <= {mem_address[31:5], 5'b0};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid[lat_idx] <= 1'b1;
                        pmem_read      <= 1'b0;
                        state          <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag contents need no reset; the cleared valid bits mask them
    always_ff @(posedge clk) begin
        if ((state == FILL) && pmem_resp && !rst)
            tags[lat_idx] <= lat_tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle_hit && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (idle_miss && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_bk_control.sv
// Directed bench for icache_bk_control with a behavioural data array; counter checks when ICACHE_PERF_CNT_EN is set.
module tb_icache_bk_control;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         data_web;
    logic [2:0]   data_index;
    logic [255:0] data_datain;
    logic [255:0] data_dataout;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] arr [8];
    logic [255:0] line_a;
    logic [255:0] line_b;

    always #5 clk = ~clk;

    icache_bk_control dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .data_web(data_web), .data_index(data_index),
        .data_datain(data_datain), .data_dataout(data_dataout)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Behavioural data array: synchronous write, combinational read
    always @(posedge clk) if (data_web) arr[data_index] <= data_datain;
    assign data_dataout = arr[data_index];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            arr[i] = '0;
            line_a[32*i +: 32] = 32'hA000_0000 + i;
            line_b[32*i +: 32] = 32'hB000_0000 + i;
        end
        line_a[63:32] = 32'hDEAD_BEEF;

        rst = 1'b1; mem_read = 1'b0; mem_address = 32'h0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        check_eq("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
        check_eq("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
        check_eq("rst_data_web", {31'b0, data_web}, 32'd0);
        check_eq("rst_pmem_address", pmem_address, 32'h0);
        check_eq("rst_data_index", {29'b0, data_index}, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'h0);

        // Cold miss on 0x104
        tick(); rst = 1'b0; mem_read = 1'b1; mem_address = 32'h0000_0104;
        @(negedge clk); check_eq("miss1_no_resp", {31'b0, mem_resp}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("fill1_pmem_read", {31'b0, pmem_read}, 32'd1);
        check_eq("fill1_pmem_address", pmem_address, 32'h0000_0100);
        check_eq("fill1_web_idle", {31'b0, data_web}, 32'd0);
        tick(); pmem_resp = 1'b1; pmem_rdata = line_a;
        @(negedge clk);
        check_eq("fill1_web", {31'b0, data_web}, 32'd1);
        check_eq("fill1_index", {29'b0, data_index}, 32'd0);
        check_eq("fill1_no_resp", {31'b0, mem_resp}, 32'd0);
        tick(); pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("resp1_mem_resp", {31'b0, mem_resp}, 32'd1);
        check_eq("resp1_rdata", mem_rdata, 32'hDEAD_BEEF);
        check_eq("resp1_pmem_read", {31'b0, pmem_read}, 32'd0);

        // Same-cycle hit on word2
        tick(); mem_address = 32'h0000_0108;
        @(negedge clk);
        check_eq("hit108_resp", {31'b0, mem_resp}, 32'd1);
        check_eq("hit108_rdata", mem_rdata, 32'hA000_0002);
        check_eq("hit108_pmem_read", {31'b0, pmem_read}, 32'd0);

        // Conflict miss replaces set 0
        tick(); mem_address = 32'h0000_1104;
        @(negedge clk); check_eq("miss1104_no_resp", {31'b0, mem_resp}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("fill1104_pmem_address", pmem_address, 32'h0000_1100);
        check_eq("fill1104_pmem_read", {31'b0, pmem_read}, 32'd1);
        tick(); pmem_resp = 1'b1; pmem_rdata = line_b;
        @(negedge clk); check_eq("fill1104_web", {31'b0, data_web}, 32'd1);
        tick(); pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("resp1104_resp", {31'b0, mem_resp}, 32'd1);
        check_eq("resp1104_rdata", mem_rdata, 32'hB000_0001);

        // 0x104 now misses; requester drops and disturbs the request mid-fill
        tick(); mem_address = 32'h0000_0104;
        @(negedge clk); check_eq("remiss104_no_resp", {31'b0, mem_resp}, 32'd0);
        tick(); mem_read = 1'b0; mem_address = 32'h0000_01F4;
        @(negedge clk);
        check_eq("fill104_pmem_address", pmem_address, 32'h0000_0100);
        check_eq("fill104_pmem_read", {31'b0, pmem_read}, 32'd1);
        tick(); pmem_resp = 1'b1; pmem_rdata = line_a;
        @(negedge clk);
        check_eq("fill104_web", {31'b0, data_web}, 32'd1);
        check_eq("fill104_index", {29'b0, data_index}, 32'd0);
        tick(); pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("resp_dropped_no_resp", {31'b0, mem_resp}, 32'd0);
        check_eq("resp_dropped_pmem_read", {31'b0, pmem_read}, 32'd0);

        // Line installed despite dropped request: four more hits
        tick(); mem_read = 1'b1; mem_address = 32'h0000_0104;
        @(negedge clk);
        check_eq("hit104_resp", {31'b0, mem_resp}, 32'd1);
        check_eq("hit104_rdata", mem_rdata, 32'hDEAD_BEEF);
        tick(); mem_address = 32'h0000_0100;
        @(negedge clk); check_eq("hit100_rdata", mem_rdata, 32'hA000_0000);
        tick(); mem_address = 32'h0000_011C;
        @(negedge clk); check_eq("hit11C_rdata", mem_rdata, 32'hA000_0007);
        tick(); mem_address = 32'h0000_010C;
        @(negedge clk);
        check_eq("hit10C_resp", {31'b0, mem_resp}, 32'd1);
        check_eq("hit10C_rdata", mem_rdata, 32'hA000_0003);

        // Stray pmem_resp in IDLE is ignored
        tick(); mem_read = 1'b0; pmem_resp = 1'b1;
        @(negedge clk);
        check_eq("idle_pmem_resp_web", {31'b0, data_web}, 32'd0);
        check_eq("idle_pmem_resp_read", {31'b0, pmem_read}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check_eq("miss_count", miss_count, 32'd3);
        check_eq("hit_count", hit_count, 32'd5);
`endif
        tick(); pmem_resp = 1'b0;
        @(negedge clk); check_eq("idle_after_stray", {31'b0, pmem_read}, 32'd0);

        // Reset in the middle of a fill
        tick(); mem_read = 1'b1; mem_address = 32'h0000_2208;
        @(negedge clk); check_eq("miss2208_no_resp", {31'b0, mem_resp}, 32'd0);
        tick();
        @(negedge clk); check_eq("fill2208_pmem_read", {31'b0, pmem_read}, 32'd1);
        #2 rst = 1'b1;
        #1 check_eq("async_rst_pmem_read", {31'b0, pmem_read}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check_eq("rst_miss_count", miss_count, 32'd0);
        check_eq("rst_hit_count", hit_count, 32'd0);
`endif
        tick(); rst = 1'b0; mem_address = 32'h0000_0104;
        @(negedge clk); check_eq("post_rst_104_miss", {31'b0, mem_resp}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("post_rst_fill_read", {31'b0, pmem_read}, 32'd1);
        check_eq("post_rst_fill_addr", pmem_address, 32'h0000_0100);
        mem_read = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
